// File: rtl/spacelink_pkg.sv
// Shared types and constants for the spacelink tone path.
package spacelink_pkg;

  localparam int unsigned SINE_W = 20;

  localparam logic [1:0] SEL_F100 = 2'd0;
  localparam logic [1:0] SEL_F200 = 2'd1;
  localparam logic [1:0] SEL_F400 = 2'd2;
  localparam logic [1:0] SEL_F800 = 2'd3;

  typedef enum logic [1:0] {
    StIdle,
    StGrant,
    StPlay,
    StGuard
  } tone_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first asserted request at or above rr_ptr, with wrap.
module rr_arbiter #(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] rr_ptr,
  output logic [NREQ-1:0]         win,
  output logic [$clog2(NREQ)-1:0] win_idx
);

  localparam int unsigned IDX_W = $clog2(NREQ);

  // Scan from the farthest slot down to rr_ptr so the nearest request is written last.
  always_comb begin
    win     = '0;
    win_idx = '0;
    for (int k = int'(NREQ) - 1; k >= 0; k--) begin
      int idx;
      idx = (int'(rr_ptr) + k) % int'(NREQ);
      if (req[idx]) begin
        win      = '0;
        win[idx] = 1'b1;
        win_idx  = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/tone_scheduler.sv
// Round-robin scheduler sharing one sinegen among NREQ requesters; gates the sample stream.
module tone_scheduler
  import spacelink_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned DUR_W = 16,
  parameter int unsigned GAP   = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NREQ-1:0]          req,
  input  logic [2*NREQ-1:0]        req_sel,
  input  logic [DUR_W*NREQ-1:0]    req_dur,
  input  logic                     abort,
  input  logic signed [SINE_W-1:0] sine_in,
  output logic [NREQ-1:0]          grant,
  output logic [NREQ-1:0]          done,
  output logic [$clog2(NREQ)-1:0]  owner,
  output logic [1:0]               gen_sel,
  output logic                     gen_reset,
  output logic                     tone_active,
  output logic                     busy,
  output logic signed [SINE_W-1:0] sine_out
);

  localparam int unsigned IDX_W = $clog2(NREQ);
  localparam int unsigned GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP - 1);
  localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(NREQ - 1);

  tone_state_t state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [DUR_W-1:0] cnt_q, cnt_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             zero_q, zero_d;
  logic [1:0]       gen_sel_q, gen_sel_d;
  logic [NREQ-1:0]  grant_q, grant_d;
  logic [NREQ-1:0]  done_q, done_d;
  logic             gen_reset_q, tone_active_q, busy_q;
  logic signed [SINE_W-1:0] sine_out_q;

  logic [NREQ-1:0]  win;
  logic [IDX_W-1:0] win_idx;
  logic [DUR_W-1:0] win_dur;
  logic             any_req;
  logic             tone_end;

  rr_arbiter #(
    .NREQ(NREQ)
  ) u_arb (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .win    (win),
    .win_idx(win_idx)
  );

  assign any_req  = |req;
  assign win_dur  = req_dur[DUR_W*win_idx +: DUR_W];
  assign tone_end = (state_q == StPlay) && ((cnt_q == '0) || abort);

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    gap_d     = gap_q;
    zero_d    = zero_q;
    gen_sel_d = gen_sel_q;
    grant_d   = '0;
    done_d    = '0;
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          state_d   = StGrant;
          grant_d   = win;
          owner_d   = win_idx;
          gen_sel_d = req_sel[2*win_idx +: 2];
          // A zero duration wraps cnt, but zero_q keeps PLAY from ever seeing it.
          cnt_d     = win_dur - 1'b1;
          zero_d    = (win_dur == '0);
          rr_ptr_d  = (win_idx == IDX_MAX) ? '0 : win_idx + 1'b1;
        end
      end
      StGrant: begin
        if (zero_q) begin
          state_d         = StGuard;
          gap_d           = GAP_LAST;
          done_d[owner_q] = 1'b1;
        end else begin
          state_d = StPlay;
        end
      end
      StPlay: begin
        if (tone_end) begin
          state_d         = StGuard;
          gap_d           = GAP_LAST;
          done_d[owner_q] = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StGuard: begin
        if (gap_q == '0) begin
          state_d = StIdle;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      rr_ptr_q      <= '0;
      owner_q       <= '0;
      cnt_q         <= '0;
      gap_q         <= '0;
      zero_q        <= 1'b0;
      gen_sel_q     <= '0;
      grant_q       <= '0;
      done_q        <= '0;
      gen_reset_q   <= 1'b1;
      tone_active_q <= 1'b0;
      busy_q        <= 1'b0;
      sine_out_q    <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      owner_q       <= owner_d;
      cnt_q         <= cnt_d;
      gap_q         <= gap_d;
      zero_q        <= zero_d;
      gen_sel_q     <= gen_sel_d;
      grant_q       <= grant_d;
      done_q        <= done_d;
      // GRANT keeps the generator in reset so PLAY opens at phase 0.
      gen_reset_q   <= (state_d != StPlay);
      tone_active_q <= (state_d == StPlay);
      busy_q        <= (state_d != StIdle);
      sine_out_q    <= tone_active_q ? sine_in : '0;
    end
  end

  assign grant       = grant_q;
  assign done        = done_q;
  assign owner       = owner_q;
  assign gen_sel     = gen_sel_q;
  assign gen_reset   = gen_reset_q;
  assign tone_active = tone_active_q;
  assign busy        = busy_q;
  assign sine_out    = sine_out_q;

endmodule

// File: doc/tone_scheduler.md
# tone_scheduler

Shares one `sinegen` tone generator among `NREQ` requesters. Each requester asks for a tone at a frequency code for a given number of cycles. A round-robin arbiter grants requests one at a time, drives the generator's `sel` and `reset`, and gates the generator's sample stream onto a registered output. The block sits between the telemetry/beacon control logic and the `sinegen` instance.

## Interface
Parameters:
- `NREQ`, 4: number of requesters; legal range 2–8.
- `DUR_W`, 16: width of the tone duration field, in cycles.
- `GAP`, 2: guard cycles between tones; must be ≥ 1.

Ports:
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `req` in `NREQ`: request level per requester; held high until granted.
- `req_sel` in `2*NREQ`: frequency code for requester i, in bits `[2i+1:2i]`.
- `req_dur` in `DUR_W*NREQ`: tone length in cycles for requester i.
- `abort` in 1: ends the current tone early.
- `sine_in` in 20 signed: sample from `sinegen.sine`.
- `grant` out `NREQ`: one-hot, one-cycle pulse when a request is accepted.
- `done` out `NREQ`: one-hot, one-cycle pulse when the granted tone ends.
- `owner` out `$clog2(NREQ)`: index of the current or last granted requester.
- `gen_sel` out 2: drives `sinegen.sel`.
- `gen_reset` out 1: drives `sinegen.reset` (active-high).
- `tone_active` out 1: high during PLAY.
- `busy` out 1: high in every state except IDLE.
- `sine_out` out 20 signed: gated sample stream.

## Operation
- FSM states: IDLE, GRANT, PLAY, GUARD. All outputs are registered.
- IDLE
  - `gen_reset` = 1.
  - If any `req` is high, pick a winner by round-robin, searching from `rr_ptr` upward with wrap.
  - Next state is GRANT.
- GRANT (1 cycle)
  - `grant[w]` = 1; `owner` = w.
  - Latch `gen_sel` ← `req_sel[w]`; load `cnt` ← `req_dur[w]` − 1.
  - Set `rr_ptr` ← w + 1, wrapping modulo `NREQ`.
  - If `req_dur[w]` = 0: pulse `done[w]` in the next cycle and go to GUARD. PLAY is skipped.
  - Otherwise go to PLAY.
- PLAY
  - `gen_reset` = 0 and `tone_active` = 1.
  - `cnt` decrements each cycle.
  - When `cnt` = 0 or `abort` = 1: go to GUARD with `done[owner]` = 1 in the first GUARD cycle.
  - PLAY therefore lasts exactly `req_dur` cycles unless aborted.
- GUARD (`GAP` cycles)
  - `gen_reset` = 1; `tone_active` = 0.
  - Then go to IDLE.
- `gen_sel` holds its value outside GRANT.
- `sine_out` ← `tone_active` ? `sine_in` : 0, with one cycle of latency. No arithmetic is applied; the width stays 20 bits signed.
- `abort` is ignored outside PLAY.
- A requester that drops `req` before its grant is never granted.
- A `req` that is high during GRANT, PLAY or GUARD is only evaluated in IDLE.
- A requester that keeps `req` high after its grant is re-requesting. Round-robin prevents it from starving the others.

## Timing
- Reset values: state IDLE, `rr_ptr` 0, `owner` 0, `gen_sel` 0, `gen_reset` 1, and all other outputs 0.
- Asserting `reset_n` mid-tone drops to IDLE immediately. No `done` pulse is issued.
- Request sampled in IDLE at edge t:
  - `grant` is high in cycle t+1.
  - PLAY starts at t+2; `sinegen.phase` = 0 in that cycle.
  - The first nonzero `sine_out` appears no earlier than t+3.
- Duration D ≥ 1:
  - `tone_active` is high for D cycles.
  - `done` is high in the cycle after the last PLAY cycle.
  - The next grant comes no earlier than D + `GAP` + 2 cycles after the previous grant.
- Same-edge `abort` and `cnt` = 0: one `done` pulse only.
- `req_dur` at its maximum (2^`DUR_W` − 1) must not overflow `cnt`.

## Structure
- Shared package `spacelink_pkg` holds:
  - the state enum `tone_state_t`;
  - the frequency-code constants `SEL_F100`, `SEL_F200`, `SEL_F400`, `SEL_F800` (codes 0–3);
  - `SINE_W` = 20.
- Sub-module `rr_arbiter` (parameter `NREQ`): inputs `req`, `rr_ptr`; outputs a one-hot winner and its index. It is purely combinational.
- The `sinegen` instance lives outside this block, in the integration level.

## Test plan
- Single request: `req[1]` with sel = 2, dur = 5, `GAP` = 2.
  - `grant` = 4'b0010 at t+1; `gen_sel` = 2.
  - `tone_active` high for 5 cycles.
  - `done[1]` at t+7; `busy` low at t+9.
- Simultaneous requests: `req` = 4'b1111 held continuously, all dur = 3.
  - Grant order is 0, 1, 2, 3, 0.
  - Grants are exactly 3 + `GAP` + 2 = 7 cycles apart.
- Zero duration: dur = 0.
  - `tone_active` never rises.
  - `done` one cycle after `grant`; `sine_out` stays 0.
- Abort: abort 2 cycles into a dur = 100 tone.
  - `done` on the next cycle; `tone_active` low.
  - `gen_reset` high; `sine_out` 0 one cycle later.
- Reset mid-tone: drop `reset_n` in PLAY.
  - All outputs go to reset values asynchronously; no `done` pulse.
  - After release, `rr_ptr` = 0 and `req[0]` wins.
- Gating: with `sinegen` attached, sel = 3, dur = 40.
  - `sine_out` matches `sine_in`, delayed one cycle, while active.
  - `sine_out` is 0 otherwise; peak value reaches ±524287.
